// File: rtl/mem_handshake_responder.sv
// Four-phase request/acknowledge responder in front of a 512-byte big-endian store.
// Requests are latched on capture; commit and read happen on the edge that enters ACK.
//
// state  | meaning
// S_IDLE | waiting for mov; captures the request on the first edge it is high
// S_WAIT | down-counting wait states; mov low here aborts the request
// S_ACK  | write committed / read data held; moc raised, waits for mov low
module mem_handshake_responder #(
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  access_type,
  input  logic [8:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] W_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic [8:0]  addr_q;
  logic [1:0]  type_q;
  logic        rw_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic [7:0]  mem [512];

  logic [8:0]  cur_addr, a1, a2, a3;
  logic [1:0]  cur_type;
  logic        cur_rw;
  logic [31:0] cur_wdata;
  logic        cur_fault;
  logic [31:0] rd_val;
  logic        enter_ack;
  logic        wr_en;

  // With zero wait states ACK is entered on the capture edge, so the live inputs
  // stand in for the latches that are being loaded on that same edge.
  assign cur_addr  = (state == S_IDLE) ? address     : addr_q;
  assign cur_type  = (state == S_IDLE) ? access_type : type_q;
  assign cur_rw    = (state == S_IDLE) ? rw          : rw_q;
  assign cur_wdata = (state == S_IDLE) ? data_in     : wdata_q;
  assign a1 = cur_addr + 9'd1;
  assign a2 = cur_addr + 9'd2;
  assign a3 = cur_addr + 9'd3;

  assign cur_fault = (cur_type == 2'b11) ||
                     (cur_type == 2'b01 && cur_addr[0]) ||
                     (cur_type == 2'b10 && cur_addr[1:0] != 2'b00);

  assign enter_ack = mov && (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                             ((state == S_WAIT) && (cnt == 4'd0)));
  assign wr_en = clr_n && enter_ack && !cur_rw && !cur_fault;

  always_comb begin
    rd_val = 32'd0;
    if (cur_rw && !cur_fault) begin
      case (cur_type)
        2'b00:   rd_val = {24'd0, mem[cur_addr]};
        2'b01:   rd_val = {16'd0, mem[cur_addr], mem[a1]};
        2'b10:   rd_val = {mem[cur_addr], mem[a1], mem[a2], mem[a3]};
        default: rd_val = 32'd0;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (cur_type)
        2'b00: mem[cur_addr] <= cur_wdata[7:0];
        2'b01: begin
          mem[cur_addr] <= cur_wdata[15:8];
          mem[a1]       <= cur_wdata[7:0];
        end
        2'b10: begin
          mem[cur_addr] <= cur_wdata[31:24];
          mem[a1]       <= cur_wdata[23:16];
          mem[a2]       <= cur_wdata[15:8];
          mem[a3]       <= cur_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      addr_q   <= 9'd0;
      type_q   <= 2'd0;
      rw_q     <= 1'b0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
      moc      <= 1'b0;
      err      <= 1'b0;
      data_out <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mov) begin
            addr_q  <= address;
            type_q  <= access_type;
            rw_q    <= rw;
            wdata_q <= data_in;
            if (enter_ack) begin
              state   <= S_ACK;
              rdata_q <= rd_val;
              fault_q <= cur_fault;
            end else begin
              state <= S_WAIT;
              cnt   <= W_LAST;
            end
          end
        end
        S_WAIT: begin
          if (!mov) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (enter_ack) begin
            state   <= S_ACK;
            rdata_q <= rd_val;
            fault_q <= cur_fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          // First ACK cycle publishes the captured result; outputs stay gated to 0 otherwise.
          if (!moc) begin
            moc      <= 1'b1;
            data_out <= rdata_q;
            err      <= fault_q;
          end else if (!mov) begin
            state    <= S_IDLE;
            moc      <= 1'b0;
            data_out <= 32'd0;
            err      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
